// File: rtl/time_display_scan.sv
// time_display_scan
//   Snapshots a binary hh:mm:ss.ms time once per display frame, converts each
//   field to two BCD digits with a subtract-10 FSM, and scans the six digits
//   (HH MM SS) onto a multiplexed 7-segment display with a blinking separator.
//
// Ports
//   clk_i        system clock
//   reset_i      synchronous active-high reset
//   hour_i       binary hours   (5 bits)
//   min_i        binary minutes (6 bits)
//   sec_i        binary seconds (6 bits)
//   ms_i         binary milliseconds (10 bits)
//   seg_o        segments a..g on bits 0..6 of the enabled digit
//   dp_o         decimal point of the enabled digit
//   an_o         one-hot digit enable, an_o[i] enables digit i
//   conv_done_o  one-cycle pulse in the cycle the committed digits are loaded
module time_display_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter bit BLANK_LZ    = 1'b0
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [4:0] hour_i,
   input  logic [5:0] min_i,
   input  logic [5:0] sec_i,
   input  logic [9:0] ms_i,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic [5:0] an_o,
   output logic       conv_done_o
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [5:0] AN_OFF  = ACTIVE_LOW ? 6'h3F : 6'h00;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CONV_H = 3'd1,
      CONV_M = 3'd2,
      CONV_S = 3'd3,
      COMMIT = 3'd4
   } state_t;

   // Active-high 7-segment pattern for one BCD digit.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    d_q, d_d;
   logic          first_q, first_d;
   logic [5:0]    min_snap_q, min_snap_d;
   logic [5:0]    sec_snap_q, sec_snap_d;
   logic          blink_snap_q, blink_snap_d;
   logic [5:0]    work_q, work_d;
   logic [2:0]    tens_q, tens_d;
   logic [3:0]    wd_q [6];
   logic [3:0]    wd_d [6];
   logic [3:0]    cd_q [6];
   logic [3:0]    cd_d [6];
   logic          blink_q, blink_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [5:0]    an_q, an_d;
   logic          done_q, done_d;

   logic          tc_s;
   logic          req_s;
   logic          step_last_s;
   logic [3:0]    digit_s;
   logic          blank_s;
   logic [6:0]    seg_raw_s;
   logic          dp_raw_s;
   logic [5:0]    an_raw_s;

   // Refresh counter, digit index, snapshot request and conversion FSM next state.
   always_comb begin
      cnt_d        = cnt_q;
      d_d          = d_q;
      first_d      = 1'b0;
      state_d      = state_q;
      min_snap_d   = min_snap_q;
      sec_snap_d   = sec_snap_q;
      blink_snap_d = blink_snap_q;
      work_d       = work_q;
      tens_d       = tens_q;
      wd_d         = wd_q;
      cd_d         = cd_q;
      blink_d      = blink_q;

      tc_s = (cnt_q == CW'(REFRESH_DIV - 1));
      if (tc_s) begin
         cnt_d = {CW{1'b0}};
         d_d   = (d_q == 3'd5) ? 3'd0 : d_q + 3'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      // A frame begins right after reset and whenever the scan wraps 5 -> 0.
      req_s       = first_q | (tc_s & (d_q == 3'd5));
      step_last_s = (work_q < 6'd10);

      case (state_q)
         IDLE: begin
            if (req_s) begin
               work_d       = {1'b0, hour_i};
               tens_d       = 3'd0;
               min_snap_d   = min_i;
               sec_snap_d   = sec_i;
               blink_snap_d = (ms_i < 10'd500);
               state_d      = CONV_H;
            end else begin
               state_d = IDLE;
            end
         end
         CONV_H: begin
            if (step_last_s) begin
               wd_d[5] = {1'b0, tens_q};
               wd_d[4] = work_q[3:0];
               work_d  = min_snap_q;
               tens_d  = 3'd0;
               state_d = CONV_M;
            end else begin
               work_d = work_q - 6'd10;
               tens_d = tens_q + 3'd1;
            end
         end
         CONV_M: begin
            if (step_last_s) begin
               wd_d[3] = {1'b0, tens_q};
               wd_d[2] = work_q[3:0];
               work_d  = sec_snap_q;
               tens_d  = 3'd0;
               state_d = CONV_S;
            end else begin
               work_d = work_q - 6'd10;
               tens_d = tens_q + 3'd1;
            end
         end
         CONV_S: begin
            if (step_last_s) begin
               wd_d[1] = {1'b0, tens_q};
               wd_d[0] = work_q[3:0];
               tens_d  = 3'd0;
               state_d = COMMIT;
            end else begin
               work_d = work_q - 6'd10;
               tens_d = tens_q + 3'd1;
            end
         end
         COMMIT: begin
            // All six digits and the blink flag move together so a frame is never mixed.
            cd_d    = wd_q;
            blink_d = blink_snap_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == COMMIT);
   end

   // Output stage next values from the current digit index and committed digits.
   always_comb begin
      case (d_q)
         3'd0:    digit_s = cd_q[0];
         3'd1:    digit_s = cd_q[1];
         3'd2:    digit_s = cd_q[2];
         3'd3:    digit_s = cd_q[3];
         3'd4:    digit_s = cd_q[4];
         3'd5:    digit_s = cd_q[5];
         default: digit_s = 4'd0;
      endcase
      blank_s   = BLANK_LZ && (d_q == 3'd5) && (cd_q[5] == 4'd0);
      seg_raw_s = blank_s ? 7'h00 : seg7(digit_s);
      dp_raw_s  = blink_q && ((d_q == 3'd2) || (d_q == 3'd4));
      an_raw_s  = 6'b000001 << d_q;
      if (ACTIVE_LOW) begin
         seg_d = ~seg_raw_s;
         dp_d  = ~dp_raw_s;
         an_d  = ~an_raw_s;
      end else begin
         seg_d = seg_raw_s;
         dp_d  = dp_raw_s;
         an_d  = an_raw_s;
      end
   end

   // All state and registered outputs, with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         cnt_q        <= {CW{1'b0}};
         d_q          <= 3'd0;
         first_q      <= 1'b1;
         min_snap_q   <= 6'd0;
         sec_snap_q   <= 6'd0;
         blink_snap_q <= 1'b0;
         work_q       <= 6'd0;
         tens_q       <= 3'd0;
         for (int i = 0; i < 6; i++) begin
            wd_q[i] <= 4'd0;
            cd_q[i] <= 4'd0;
         end
         blink_q      <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= ACTIVE_LOW;
         an_q         <= AN_OFF;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         d_q          <= d_d;
         first_q      <= first_d;
         min_snap_q   <= min_snap_d;
         sec_snap_q   <= sec_snap_d;
         blink_snap_q <= blink_snap_d;
         work_q       <= work_d;
         tens_q       <= tens_d;
         wd_q         <= wd_d;
         cd_q         <= cd_d;
         blink_q      <= blink_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         done_q       <= done_d;
      end
   end

   assign seg_o       = seg_q;
   assign dp_o        = dp_q;
   assign an_o        = an_q;
   assign conv_done_o = done_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Testbench for time_display_scan: three instances (different polarity/blanking)
// share the stimulus; a frame-level model predicts every output every cycle, and
// directed checks pin the model to hand-computed display values.
module tb_time_display_scan;

   localparam int DIV = 32;
   localparam int NI  = 3;
   // Per-instance parameters, indexed by instance number.
   localparam bit [2:0] AL_P = 3'b011;
   localparam bit [2:0] BL_P = 3'b110;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic [4:0] hour_i = 5'd0;
   logic [5:0] min_i = 6'd0;
   logic [5:0] sec_i = 6'd0;
   logic [9:0] ms_i = 10'd0;
   logic [6:0] seg [NI];
   logic       dp [NI];
   logic [5:0] an [NI];
   logic       done [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   time_display_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) u_a (
      .clk_i(clk), .reset_i(reset_i), .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
      .ms_i(ms_i), .seg_o(seg[0]), .dp_o(dp[0]), .an_o(an[0]), .conv_done_o(done[0]));
   time_display_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u_b (
      .clk_i(clk), .reset_i(reset_i), .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
      .ms_i(ms_i), .seg_o(seg[1]), .dp_o(dp[1]), .an_o(an[1]), .conv_done_o(done[1]));
   time_display_scan #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) u_c (
      .clk_i(clk), .reset_i(reset_i), .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
      .ms_i(ms_i), .seg_o(seg[2]), .dp_o(dp[2]), .an_o(an[2]), .conv_done_o(done[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] lo(input logic [6:0] v);
      return ~v;
   endfunction

   function automatic logic [6:0] seg_of(input int v);
      logic [6:0] tab [10];
      tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return tab[v];
   endfunction

   // {seg, dp, an} the display must show for digit position dig of time h:m:s.
   function automatic logic [13:0] expect_out(input int dig, input int h, input int m,
                                              input int s, input bit blink, input bit al,
                                              input bit bl);
      int v;
      logic [6:0] sg;
      logic p;
      logic [5:0] a;
      case (dig)
         0:       v = s % 10;
         1:       v = s / 10;
         2:       v = m % 10;
         3:       v = m / 10;
         4:       v = h % 10;
         default: v = h / 10;
      endcase
      sg = seg_of(v);
      if (bl && dig == 5 && h / 10 == 0) sg = 7'h00;
      p = blink && (dig == 2 || dig == 4);
      a = 6'b000001 << dig;
      if (al) return {~sg, ~p, ~a};
      return {sg, p, a};
   endfunction

   function automatic logic [5:0] anode_pat(input int i, input int d);
      logic [5:0] p;
      p = 6'b000001 << d;
      if (AL_P[i]) return ~p;
      return p;
   endfunction

   // ---------------- frame-level reference model ----------------
   bit          have_exp = 1'b0;
   bit          in_run = 1'b0;
   int          cyc = 0;
   bit          pending = 1'b0;
   int          commit_at = 0;
   int          sh, sm, ss;
   bit          sb;
   int          ch = 0, cm = 0, cs = 0;
   bit          cb = 1'b0;
   logic [13:0] exp_o [NI];
   logic        exp_done = 1'b0;

   always @(negedge clk) begin
      if (have_exp) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("model u%0d seg", i), seg[i], exp_o[i][13:7]);
            check($sformatf("model u%0d dp", i), dp[i], exp_o[i][6]);
            check($sformatf("model u%0d an", i), an[i], exp_o[i][5:0]);
            check($sformatf("model u%0d done", i), done[i], exp_done);
         end
      end
      have_exp = 1'b1;
      if (reset_i) begin
         in_run  = 1'b0;
         pending = 1'b0;
         ch = 0; cm = 0; cs = 0; cb = 1'b0;
         for (int i = 0; i < NI; i++)
            exp_o[i] = AL_P[i] ? {7'h7F, 1'b1, 6'h3F} : 14'd0;
         exp_done = 1'b0;
      end else begin
         int d;
         if (!in_run) begin
            in_run = 1'b1;
            cyc = 0;
         end else begin
            cyc++;
         end
         d = (cyc / DIV) % 6;
         if ((cyc == 0 || cyc % (6 * DIV) == 6 * DIV - 1) && !pending) begin
            sh = hour_i; sm = min_i; ss = sec_i; sb = (ms_i < 500);
            pending = 1'b1;
            commit_at = cyc + 1 + (sh / 10 + 1) + (sm / 10 + 1) + (ss / 10 + 1);
         end
         for (int i = 0; i < NI; i++)
            exp_o[i] = expect_out(d, ch, cm, cs, cb, AL_P[i], BL_P[i]);
         if (pending && cyc == commit_at) begin
            ch = sh; cm = sm; cs = ss; cb = sb;
            pending = 1'b0;
         end
         exp_done = pending && (commit_at == cyc + 1);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_time(input int h, input int m, input int s, input int ms);
      hour_i = 5'(h); min_i = 6'(m); sec_i = 6'(s); ms_i = 10'(ms);
   endtask

   task automatic wait_done(input int i, output int k);
      k = 0;
      while (done[i] !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
      check("wait for conv_done", (k < 400) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // Waits for a commit and until its new digits reach the outputs.
   task automatic wait_commit();
      int k;
      wait_done(0, k);
      tick();
      tick();
   endtask

   task automatic wait_an(input int i, input int d);
      int k = 0;
      while (an[i] !== anode_pat(i, d) && k < 400) begin
         tick();
         k++;
      end
      check($sformatf("wait for u%0d anode %0d", i, d), (k < 400) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int k;
      int total;
      int ovl;
      logic [6:0] exp_seg [6];

      // Power-on frame: 23:59:58.100
      set_time(23, 59, 58, 100);
      repeat (3) tick();
      reset_i = 1'b0;
      k = 0;
      while (done[0] !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      check("first conv_done within 23 cycles", (k >= 1 && k <= 23) ? 32'd1 : 32'd0, 32'd1);

      exp_seg = '{lo(7'h7F), lo(7'h6D), lo(7'h6F), lo(7'h6D), lo(7'h4F), lo(7'h5B)};
      wait_an(0, 5);
      for (int d = 0; d < 6; d++) begin
         wait_an(0, d);
         check($sformatf("23:59:58 digit %0d seg", d), seg[0], exp_seg[d]);
         check($sformatf("23:59:58 digit %0d dp", d), dp[0], (d == 2 || d == 4) ? 1'b0 : 1'b1);
      end

      // Scan timing: each anode for DIV cycles, in order, one at a time.
      wait_an(0, 0);
      total = 0;
      ovl = 0;
      for (int d = 0; d < 6; d++) begin
         k = 0;
         while (an[0] === anode_pat(0, d) && k < 100) begin
            k++;
            tick();
            if ($countones(~an[0]) != 1) ovl++;
         end
         check($sformatf("anode %0d dwell", d), k, DIV);
         total += k;
      end
      check("frame length", total, 6 * DIV);
      check("anode overlap count", ovl, 0);

      // Frame coherence: a mid-frame change waits for the next frame.
      set_time(12, 34, 56, 700);
      wait_commit();
      wait_commit();
      wait_an(0, 2);
      set_time(7, 8, 9, 700);
      wait_an(0, 5);
      check("old hour tens kept mid-frame", seg[0], lo(7'h06));
      wait_commit();
      wait_an(0, 0);
      check("new sec ones after commit", seg[0], lo(7'h6F));
      wait_an(0, 5);
      check("new hour tens after commit", seg[0], lo(7'h3F));

      // Separator blink.
      ms_i = 10'd499;
      wait_commit();
      wait_commit();
      wait_an(0, 2);
      check("ms=499 dp digit 2", dp[0], 1'b0);
      wait_an(0, 4);
      check("ms=499 dp digit 4", dp[0], 1'b0);
      ms_i = 10'd500;
      wait_commit();
      wait_commit();
      wait_an(0, 2);
      check("ms=500 dp digit 2", dp[0], 1'b1);
      wait_an(0, 4);
      check("ms=500 dp digit 4", dp[0], 1'b1);

      // Leading-zero blanking of hour tens.
      set_time(5, 0, 0, 0);
      wait_commit();
      wait_commit();
      wait_an(1, 5);
      check("blank hour tens seg", seg[1], 7'h7F);
      check("blank hour tens anode", an[1], 6'b011111);
      check("blank hour tens seg active-high", seg[2], 7'h00);
      check("no blanking when disabled", seg[0], lo(7'h3F));
      wait_an(1, 4);
      check("hour ones 5", seg[1], lo(7'h6D));
      hour_i = 5'd24;
      wait_commit();
      wait_commit();
      wait_an(1, 5);
      check("hour 24 tens", seg[1], lo(7'h5B));
      wait_an(1, 4);
      check("hour 24 ones", seg[1], lo(7'h66));

      // Reset in the middle of a conversion.
      set_time(31, 63, 63, 0);
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
      repeat (5) tick();
      reset_i = 1'b1;
      tick();
      check("mid-conv reset an", an[0], 6'b111111);
      check("mid-conv reset seg", seg[0], 7'h7F);
      check("mid-conv reset done", done[0], 1'b0);
      check("mid-conv reset an active-high", an[2], 6'b000000);
      reset_i = 1'b0;
      wait_done(0, k);
      check("post-reset conv latency", (k <= 23) ? 32'd1 : 32'd0, 32'd1);
      tick();
      tick();
      wait_an(0, 0);
      check("31:63:63 sec ones", seg[0], lo(7'h4F));
      wait_an(0, 1);
      check("31:63:63 sec tens", seg[0], lo(7'h7D));
      wait_an(0, 3);
      check("31:63:63 min tens", seg[0], lo(7'h7D));
      wait_an(0, 4);
      check("31:63:63 hour ones", seg[0], lo(7'h06));
      wait_an(0, 5);
      check("31:63:63 hour tens", seg[0], lo(7'h4F));

      // Random input changes and occasional resets, checked by the model.
      for (int it = 0; it < 4000; it++) begin
         if ($urandom_range(0, 7) == 0)
            set_time($urandom_range(0, 31), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 1023));
         reset_i = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset_i = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
